// File: rtl/sparc_exu_ecl_ccrwb_pkg.sv
// Shared definitions for the CCR write-back staging block and the CCR store.
//   NTHR / CCW        : thread count and condition-code width
//   XCC_* / ICC_*     : field offsets inside a {xcc, icc} CC word
//   thr_dec / thr_inc : thread-id decode to one-hot, and wrap-around increment
package sparc_exu_ecl_ccrwb_pkg;

    localparam int unsigned NTHR   = 4;
    localparam int unsigned CCW    = 8;
    localparam int unsigned THRW   = 2;

    localparam int unsigned XCC_HI = 7;
    localparam int unsigned XCC_LO = 4;
    localparam int unsigned ICC_HI = 3;
    localparam int unsigned ICC_LO = 0;

    typedef logic [THRW-1:0] thr_t;
    typedef logic [NTHR-1:0] thr_vec_t;
    typedef logic [CCW-1:0]  cc_t;

    function automatic thr_vec_t thr_dec(input thr_t t);
        thr_vec_t v;
        v    = '0;
        v[t] = 1'b1;
        return v;
    endfunction

    // Wraps modulo NTHR because THRW bits cover exactly NTHR threads.
    function automatic thr_t thr_inc(input thr_t t);
        return t + thr_t'(1);
    endfunction

endpackage

// File: rtl/sparc_exu_ecl_ccrwb_if.sv
// Condition-code write-back bus between the divide control, this staging block
// and the CCR store.
//   divcntl_wb_req/thr/cc : long-latency CC result arriving from divide control
//   wb_ccr_busy           : W2 slot of the CCR write port is taken this cycle
//   wb_ccr_setcc_g/thr_g  : G-stage W2 write request toward the CCR store
//   divcntl_ccr_cc_w2     : W2-stage CC data, one cycle after setcc_g
// slave is the staging block's view; master is the environment's view.
interface sparc_exu_ecl_ccrwb_if import sparc_exu_ecl_ccrwb_pkg::*; ();

    logic divcntl_wb_req;
    thr_t divcntl_wb_thr;
    cc_t  divcntl_wb_cc;
    logic wb_ccr_busy;
    logic wb_ccr_setcc_g;
    thr_t wb_ccr_thr_g;
    cc_t  divcntl_ccr_cc_w2;

    modport slave (
        input  divcntl_wb_req, divcntl_wb_thr, divcntl_wb_cc, wb_ccr_busy,
        output wb_ccr_setcc_g, wb_ccr_thr_g, divcntl_ccr_cc_w2
    );

    modport master (
        output divcntl_wb_req, divcntl_wb_thr, divcntl_wb_cc, wb_ccr_busy,
        input  wb_ccr_setcc_g, wb_ccr_thr_g, divcntl_ccr_cc_w2
    );

endinterface

// File: rtl/sparc_exu_ecl_ccrwb_rr_arb4.sv
// Four-requester round-robin arbiter with an external priority pointer.
//   req     : per-thread request vector
//   ptr     : thread with highest priority this cycle
//   gnt     : one-hot grant
//   gnt_enc : encoded grant (0 when nothing granted)
//   vld     : a grant was issued
module sparc_exu_rr_arb4 import sparc_exu_ecl_ccrwb_pkg::*; (
    input  thr_vec_t req,
    input  thr_t     ptr,
    output thr_vec_t gnt,
    output thr_t     gnt_enc,
    output logic     vld
);

    thr_t idx;

    // Walk ptr, ptr+1, ... (mod NTHR) and take the first requester.
    always_comb begin
        gnt     = '0;
        gnt_enc = '0;
        vld     = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NTHR; i++) begin
            idx = ptr + thr_t'(i);
            if (!vld && req[idx]) begin
                vld      = 1'b1;
                gnt_enc  = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sparc_exu_ecl_ccrwb.sv
// Holds long-latency condition-code results (divide/multiply xcc/icc), one entry
// per thread, until the CCR write port's W2 slot is free, then issues them to the
// CCR store one per cycle in round-robin order.
//   clk, rst          : core clock, asynchronous active-high reset
//   ccr_if (slave)    : result input, busy, G-stage request and W2 data
//   ifu_exu_flush_thr : per-thread kill of the pending entry
//   ccrwb_pend        : per-thread entry occupied (registered)
//   ccrwb_ovf         : one-cycle pulse, a result was dropped on an occupied entry
module sparc_exu_ecl_ccrwb import sparc_exu_ecl_ccrwb_pkg::*; (
    input  logic                        clk,
    input  logic                        rst,
    sparc_exu_ecl_ccrwb_if.slave        ccr_if,
    input  thr_vec_t                    ifu_exu_flush_thr,
    output thr_vec_t                    ccrwb_pend,
    output logic                        ccrwb_ovf
);

    thr_vec_t pend;
    thr_vec_t elig;
    thr_vec_t arb_req;
    thr_vec_t gnt_oh;
    thr_vec_t req_oh;
    thr_vec_t load;
    thr_vec_t drop;
    thr_t     rr_ptr;
    thr_t     gnt_enc;
    logic     gnt_vld;
    cc_t      cc_q [NTHR];
    cc_t      cc_w2_q;
    logic     ovf_q;

    // Eligibility comes only from the pend flops, so a result can never be
    // granted in the cycle it arrives.
    assign elig    = pend & ~ifu_exu_flush_thr;
    assign arb_req = ccr_if.wb_ccr_busy ? '0 : elig;

    sparc_exu_rr_arb4 u_arb (
        .req     (arb_req),
        .ptr     (rr_ptr),
        .gnt     (gnt_oh),
        .gnt_enc (gnt_enc),
        .vld     (gnt_vld)
    );

    // An occupied entry accepts a new result only if it drains this cycle;
    // a flush to the same thread kills the request without an overflow.
    assign req_oh = ccr_if.divcntl_wb_req ? thr_dec(ccr_if.divcntl_wb_thr) : '0;
    assign load   = req_oh & ~ifu_exu_flush_thr & (~pend | gnt_oh);
    assign drop   = req_oh & ~ifu_exu_flush_thr & pend & ~gnt_oh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend    <= '0;
            rr_ptr  <= '0;
            cc_w2_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pend  <= (pend & ~gnt_oh & ~ifu_exu_flush_thr) | load;
            ovf_q <= |drop;
            if (gnt_vld) begin
                rr_ptr  <= thr_inc(gnt_enc);
                cc_w2_q <= cc_q[gnt_enc];
            end
        end
    end

    // Entry data is qualified by pend, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int unsigned t = 0; t < NTHR; t++) begin
            if (load[t]) begin
                cc_q[t] <= ccr_if.divcntl_wb_cc;
            end
        end
    end

    assign ccr_if.wb_ccr_setcc_g    = gnt_vld;
    assign ccr_if.wb_ccr_thr_g      = gnt_vld ? gnt_enc : '0;
    assign ccr_if.divcntl_ccr_cc_w2 = cc_w2_q;
    assign ccrwb_pend               = pend;
    assign ccrwb_ovf                = ovf_q;

endmodule

// File: tb/tb_sparc_exu_ecl_ccrwb.sv
module tb_sparc_exu_ecl_ccrwb;
    import sparc_exu_ecl_ccrwb_pkg::*;

    logic     clk;
    logic     rst;
    thr_vec_t flush;
    thr_vec_t pend;
    logic     ovf;
    int       n_cmp;
    int       n_err;

    sparc_exu_ecl_ccrwb_if bus ();

    sparc_exu_ecl_ccrwb dut (
        .clk               (clk),
        .rst               (rst),
        .ccr_if            (bus),
        .ifu_exu_flush_thr (flush),
        .ccrwb_pend        (pend),
        .ccrwb_ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input thr_t thr, input cc_t cc,
                         input logic busy, input thr_vec_t fl);
        bus.divcntl_wb_req = req;
        bus.divcntl_wb_thr = thr;
        bus.divcntl_wb_cc  = cc;
        bus.wb_ccr_busy    = busy;
        flush              = fl;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_g(input string tag, input logic setcc, input thr_t thr);
        chk({tag, "_setcc"}, 32'(bus.wb_ccr_setcc_g), 32'(setcc));
        chk({tag, "_thr"},   32'(bus.wb_ccr_thr_g),   32'(thr));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.divcntl_wb_req = 1'b0;
        bus.divcntl_wb_thr = '0;
        bus.divcntl_wb_cc  = '0;
        bus.wb_ccr_busy    = 1'b0;
        flush              = '0;
        tick();
        tick();
        chk("rst_pend", 32'(pend), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_ccw2", 32'(bus.divcntl_ccr_cc_w2), 32'h0);
        chk_g("rst", 1'b0, 2'd0);
        rst = 1'b0;
        tick();

        // 1: single result, minimum latency
        drive(1'b1, 2'd2, 8'hA5, 1'b0, 4'b0000);
        chk_g("t1_arrival", 1'b0, 2'd0);
        tick();
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
        chk_g("t1_grant", 1'b1, 2'd2);
        chk("t1_pend1", 32'(pend), 32'h4);
        tick();
        chk("t1_ccw2", 32'(bus.divcntl_ccr_cc_w2), 32'hA5);
        chk("t1_pend2", 32'(pend), 32'h0);
        chk_g("t1_idle", 1'b0, 2'd0);

        // rr_ptr is 3 now; one thr3 transaction brings it back to 0
        drive(1'b1, 2'd3, 8'h3C, 1'b0, 4'b0000);
        tick();
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
        chk_g("ptr_fix", 1'b1, 2'd3);
        tick();
        chk("ptr_fix_ccw2", 32'(bus.divcntl_ccr_cc_w2), 32'h3C);

        // 2: round-robin fairness
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, thr_t'(i), cc_t'(8'h10 + i), 1'b1, 4'b0000);
            chk_g("t2_load", 1'b0, 2'd0);
            tick();
        end
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
        chk("t2_pend_full", 32'(pend), 32'hF);
        for (int i = 0; i < 4; i++) begin
            chk_g("t2_rr", 1'b1, thr_t'(i));
            tick();
            chk("t2_ccw2", 32'(bus.divcntl_ccr_cc_w2), 32'(8'h10 + i));
        end
        chk("t2_pend_empty", 32'(pend), 32'h0);
        drive(1'b1, 2'd3, 8'h23, 1'b1, 4'b0000);
        tick();
        drive(1'b1, 2'd1, 8'h21, 1'b1, 4'b0000);
        tick();
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
        chk_g("t2_refill_first", 1'b1, 2'd1);
        tick();
        chk("t2_refill_cc1", 32'(bus.divcntl_ccr_cc_w2), 32'h21);
        chk_g("t2_refill_second", 1'b1, 2'd3);
        tick();
        chk("t2_refill_cc3", 32'(bus.divcntl_ccr_cc_w2), 32'h23);

        // 3: busy holds the entry without loss (rr_ptr = 0)
        drive(1'b1, 2'd1, 8'h31, 1'b1, 4'b0000);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd0, 8'h00, 1'b1, 4'b0000);
            chk_g("t3_busy", 1'b0, 2'd0);
            chk("t3_pend_hold", 32'(pend), 32'h2);
            tick();
        end
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
        chk_g("t3_release", 1'b1, 2'd1);
        chk("t3_pend_pre", 32'(pend), 32'h2);
        tick();
        chk("t3_pend_post", 32'(pend), 32'h0);
        chk("t3_ccw2", 32'(bus.divcntl_ccr_cc_w2), 32'h31);

        // 4a: overflow on an occupied, ungranted entry (rr_ptr = 2)
        drive(1'b1, 2'd0, 8'h40, 1'b1, 4'b0000);
        tick();
        drive(1'b1, 2'd0, 8'hFF, 1'b1, 4'b0000);
        chk_g("t4a_busy", 1'b0, 2'd0);
        tick();
        chk("t4a_ovf", 32'(ovf), 32'h1);
        chk("t4a_pend", 32'(pend), 32'h1);
        drive(1'b0, 2'd0, 8'h00, 1'b1, 4'b0000);
        tick();
        chk("t4a_ovf_pulse", 32'(ovf), 32'h0);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
        chk_g("t4a_grant", 1'b1, 2'd0);
        tick();
        chk("t4a_cc_kept", 32'(bus.divcntl_ccr_cc_w2), 32'h40);

        // 4b: refill in the grant cycle (rr_ptr = 1)
        drive(1'b1, 2'd0, 8'h41, 1'b1, 4'b0000);
        tick();
        drive(1'b1, 2'd0, 8'hFF, 1'b0, 4'b0000);
        chk_g("t4b_grant1", 1'b1, 2'd0);
        tick();
        chk("t4b_no_ovf", 32'(ovf), 32'h0);
        chk("t4b_pend", 32'(pend), 32'h1);
        chk("t4b_cc1", 32'(bus.divcntl_ccr_cc_w2), 32'h41);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
        chk_g("t4b_grant2", 1'b1, 2'd0);
        tick();
        chk("t4b_cc2", 32'(bus.divcntl_ccr_cc_w2), 32'hFF);
        chk("t4b_pend_empty", 32'(pend), 32'h0);

        // 5: flush (rr_ptr = 1): thr2 would win, flush hands grant to thr3
        drive(1'b1, 2'd2, 8'h52, 1'b1, 4'b0000);
        tick();
        drive(1'b1, 2'd3, 8'h53, 1'b1, 4'b0000);
        tick();
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b0100);
        chk_g("t5_flush_grant", 1'b1, 2'd3);
        tick();
        chk("t5_pend", 32'(pend), 32'h0);
        chk("t5_ccw2", 32'(bus.divcntl_ccr_cc_w2), 32'h53);
        drive(1'b1, 2'd1, 8'h61, 1'b1, 4'b0000);
        tick();
        drive(1'b1, 2'd1, 8'h62, 1'b1, 4'b0010);
        tick();
        chk("t5_flushreq_pend", 32'(pend), 32'h0);
        chk("t5_flushreq_ovf", 32'(ovf), 32'h0);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
        chk_g("t5_idle", 1'b0, 2'd0);

        // 6: async reset mid-cycle with entries pending and ovf high (rr_ptr = 0)
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, thr_t'(i), cc_t'(8'h70 + i), 1'b1, 4'b0000);
            tick();
        end
        drive(1'b1, 2'd2, 8'h7F, 1'b1, 4'b0000);
        tick();
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
        chk("t6_ovf_pre", 32'(ovf), 32'h1);
        chk("t6_pend_pre", 32'(pend), 32'h7);
        chk_g("t6_grant_pre", 1'b1, 2'd0);
        #2;
        rst = 1'b1;
        #1;
        chk_g("t6_rst", 1'b0, 2'd0);
        chk("t6_rst_pend", 32'(pend), 32'h0);
        chk("t6_rst_ovf", 32'(ovf), 32'h0);
        chk("t6_rst_ccw2", 32'(bus.divcntl_ccr_cc_w2), 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_g("t6_quiet", 1'b0, 2'd0);
            chk("t6_quiet_pend", 32'(pend), 32'h0);
        end
        drive(1'b1, 2'd1, 8'h77, 1'b0, 4'b0000);
        tick();
        drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
        chk_g("t6_new", 1'b1, 2'd1);
        tick();
        chk("t6_new_ccw2", 32'(bus.divcntl_ccr_cc_w2), 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
